fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage ARM-subset pipeline. Holds the program counter, drives the combinational instruction memory's byte address, and captures the returned word into the IF/ID pipeline register together with PC+4 and a valid flag. It also applies hazard-unit freeze and EXE-stage branch redirect/flush. It sits directly upstream of the instruction memory read and feeds the decode stage.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- ADDR_W, 32, PC and address width.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- freeze  in  1  hazard stall; hold PC and IF/ID contents.
- branch_taken  in  1  EXE-stage redirect request.
- branch_addr  in  ADDR_W  redirect target (byte address).
- imem_addr  out  ADDR_W  byte address to instruction memory; equals PC register.
- imem_data  in  INSTR_W  instruction word returned combinationally for imem_addr.
- if_pc  out  ADDR_W  registered PC+4 of the captured instruction.
- if_instr  out  INSTR_W  registered instruction.
- if_valid  out  1  registered; 1 = if_instr is a real fetched instruction.

## Operation

- PC register: next value chosen per edge, priority high→low:
  - branch_taken=1 → {branch_addr[ADDR_W-1:2], 2'b00}; bits [1:0] are forced to zero.
  - freeze=1 → hold.
  - otherwise → PC+4, modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
- IF/ID register: updated on the same edge, with the same priority:
  - branch_taken=1 → flush: if_instr=0, if_pc=0, if_valid=0. Flush wins over freeze.
  - freeze=1 → hold all three fields, including if_valid.
  - otherwise → if_instr=imem_data, if_pc=PC+4, if_valid=1.
- imem_addr is a direct wire from the PC register. The block adds no combinational path from any input to imem_addr.
- The block does not decode instructions. Condition codes and the S bit pass through untouched.
- Asynchronous reset (rst_n=0):
  - PC=RESET_PC, so imem_addr=RESET_PC.
  - if_instr=0, if_pc=0, if_valid=0.
  - Reset takes effect immediately, mid-cycle, regardless of freeze or branch_taken. Release is sampled at the next rising edge.

## Timing

- Fetch latency is 1 cycle. The word at imem_addr in cycle n appears on if_instr after edge n+1.
- First edge after rst_n deasserts: if_instr=mem[RESET_PC>>2], if_pc=RESET_PC+4, if_valid=1, PC=RESET_PC+4.
- Branch penalty: the instruction fetched in the cycle branch_taken is high is discarded, giving one bubble (if_valid=0). The target instruction appears one edge later.
- Freeze has no limit on duration. Outputs stay bit-stable for every frozen cycle. Fetch resumes from the held PC on the first unfrozen edge.
- When branch_taken and freeze are asserted together, the result is identical to branch_taken alone.
- One register stage only. No internal buffering and no handshake beyond freeze.

## Structure

- Shared package, `arm_pkg`:
  - ADDR_W, INSTR_W.
  - RESET_PC default.
  - NOP_INSTR = 32'h0000_0000, the flush encoding.
  - PC_STEP = 4.
- One natural sub-module, `if_id_reg`: a parameterised pipeline register with clk, rst_n, freeze and flush inputs. It is reused by later inter-stage registers.
- PC register, incrementer and next-PC mux stay inline in fetch_stage.

## Test plan

- Reset/sequential fetch:
  - Stimulus: memory model with mem[0]=32'hE3A00014 and mem[1]=32'hE3A01A01. Hold rst_n low, then release it.
  - Required: imem_addr=0 while reset is held.
  - Required after edge 1: if_instr=E3A00014, if_pc=4, if_valid=1.
  - Required after edge 2: if_instr=E3A01A01, if_pc=8, imem_addr=8.
- Freeze:
  - Stimulus: freeze=1 for 3 cycles while PC=12.
  - Required: imem_addr stays 12, IF/ID outputs unchanged, if_valid unchanged.
  - Required after release: next edge captures mem[3] with if_pc=16.
- Branch:
  - Stimulus: branch_taken=1, branch_addr=32'h40 for one cycle.
  - Required next edge: PC=40, if_valid=0, if_instr=0.
  - Required following edge: if_instr=mem[16], if_pc=44.
- Branch vs freeze:
  - Stimulus: branch_taken=1, freeze=1, branch_addr=32'h23.
  - Required: PC=20 (alignment forced), IF/ID flushed, if_valid=0.
- Wrap-around:
  - Stimulus: branch to 32'hFFFF_FFFC, then one free-running edge.
  - Required: PC=0, if_pc=0.
- Async reset mid-run:
  - Stimulus: drop rst_n between edges while if_valid=1 and freeze=1.
  - Required: outputs go to reset values before the next edge.

Source files
------------

// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared constants for the 5-stage ARM-subset pipeline.
//   ADDR_W    : PC / byte-address width
//   INSTR_W   : instruction word width
//   RESET_PC  : default PC loaded on reset (word aligned)
//   NOP_INSTR : encoding placed in a pipeline register when it is flushed
//   PC_STEP   : byte distance between consecutive instructions
// -----------------------------------------------------------------------------
package arm_pkg;

  localparam int          ADDR_W    = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

endpackage : arm_pkg

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// Generic inter-stage pipeline register with a payload and a valid flag.
// Priority on each rising edge: flush > freeze > load.
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (payload=FLUSH_VAL, valid=0)
//   freeze   in   hold payload and valid
//   flush    in   replace payload with FLUSH_VAL and clear valid
//   i_data   in   WIDTH-bit payload to capture
//   i_valid  in   valid flag to capture with the payload
//   o_data   out  registered payload
//   o_valid  out  registered valid flag
// -----------------------------------------------------------------------------
module if_id_reg
  import arm_pkg::*;
#(
  parameter int               WIDTH     = ADDR_W + INSTR_W,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             flush,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Flush is checked before freeze so a redirect always discards the
  // wrong-path word, even while the downstream stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= FLUSH_VAL;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_data  <= FLUSH_VAL;
      r_valid <= 1'b0;
    end else if (!freeze) begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and captures the returned word, PC+4 and a valid flag
// into the IF/ID register. Handles hazard freeze and EXE branch redirect.
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   freeze       in   hold PC and IF/ID contents
//   branch_taken in   redirect PC to branch_addr and flush IF/ID
//   branch_addr  in   redirect target (low two bits ignored)
//   imem_addr    out  byte address to instruction memory (= PC register)
//   imem_data    in   instruction word for imem_addr (combinational)
//   if_pc        out  registered PC+4 of the captured instruction
//   if_instr     out  registered instruction
//   if_valid     out  registered; 1 = if_instr is a real fetched instruction
// -----------------------------------------------------------------------------
module fetch_stage
  import arm_pkg::*;
#(
  parameter int                ADDR_W   = arm_pkg::ADDR_W,
  parameter int                INSTR_W  = arm_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(arm_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid
);

  localparam int IFID_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_branch_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [IFID_W-1:0] w_ifid_q;

  // Natural wrap at 2^ADDR_W: the last word address rolls over to 0.
  assign w_pc_plus4  = r_pc + ADDR_W'(PC_STEP);

  // Masking instead of concatenation keeps the whole branch_addr bus in use
  // while still forcing word alignment of the target.
  assign w_branch_pc = branch_addr & ~ADDR_W'(3);

  always_comb begin
    w_pc_next = r_pc;
    if (branch_taken) begin
      w_pc_next = w_branch_pc;
    end else if (!freeze) begin
      w_pc_next = w_pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // The memory address comes straight from the PC flop; no input reaches it
  // combinationally.
  assign imem_addr = r_pc;

  if_id_reg #(
    .WIDTH     (IFID_W),
    .FLUSH_VAL ({{ADDR_W{1'b0}}, INSTR_W'(NOP_INSTR)})
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .freeze  (freeze),
    .flush   (branch_taken),
    .i_data  ({w_pc_plus4, imem_data}),
    .i_valid (1'b1),
    .o_data  (w_ifid_q),
    .o_valid (if_valid)
  );

  assign if_pc    = w_ifid_q[IFID_W-1:INSTR_W];
  assign if_instr = w_ifid_q[INSTR_W-1:0];

endmodule : fetch_stage
